mem_stage_sram: RTL and testbench
=================================

# mem_stage_sram

Memory stage of the ARM968E-S pipeline, placed directly downstream of the EXE stage register and upstream of the MEM/WB register. It turns a 32-bit load or store from the EXE stage register into two 16-bit accesses on an external SRAM with configurable wait states. Non-memory instructions pass straight through. While an access is in progress it drives `ready` low, and the pipeline-wide `freeze = ~ready` stalls every stage register.

## Interface
Parameters:
- `SRAM_WAIT`, default 1: extra cycles per halfword phase, so each phase lasts `SRAM_WAIT+1` cycles. Legal range 0..15.
- `BASE_ADDR`, default 1024: byte address that maps to SRAM word 0.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1: rising-edge clock.
- `rst`  in  1: asynchronous active-high reset.
- `WB_en_in`  in  1: write-back enable from the EXE stage register.
- `MEM_R_EN_in`  in  1: load request.
- `MEM_W_EN_in`  in  1: store request.
- `ALU_result_in`  in  32: byte address, or the ALU result for non-memory instructions.
- `ST_val_in`  in  32: store data.
- `Dest_in`  in  4: destination register.
- `WB_en`  out  1: equals `WB_en_in`, combinational.
- `MEM_R_EN`  out  1: equals `MEM_R_EN_in`, combinational.
- `ALU_result`  out  32: equals `ALU_result_in`, combinational.
- `Dest`  out  4: equals `Dest_in`, combinational.
- `MEM_result`  out  32: last completed read word, registered.
- `ready`  out  1: low while an access is pending.
- `SRAM_ADDR`  out  18: halfword address to the SRAM.
- `SRAM_WDATA`  out  16: write data to the SRAM.
- `SRAM_RDATA`  in  16: read data from the SRAM.
- `SRAM_WE_N`  out  1: write enable, active low.

## Operation
- Request: `req = MEM_R_EN_in | MEM_W_EN_in`. If both are set, the access is a write; the read is ignored.
- Word address: `waddr[16:0] = (ALU_result_in - BASE_ADDR) >> 2`. The subtraction is 32-bit and truncates to 17 bits. An address below `BASE_ADDR` wraps; no error is raised.
- State machine: IDLE, LO, HI, DONE.
  - IDLE with `req=1` goes to LO and clears the wait counter. IDLE with `req=0` stays in IDLE.
  - LO: `SRAM_ADDR={waddr,1'b0}`. On a write, `SRAM_WDATA=ST_val_in[15:0]`. On the edge where the counter equals `SRAM_WAIT`: a read latches `SRAM_RDATA` into `MEM_result[15:0]`; the counter clears; next state is HI.
  - HI: same as LO with `SRAM_ADDR={waddr,1'b1}`, `ST_val_in[31:16]` as write data and `MEM_result[31:16]` as the read target. Next state is DONE.
  - DONE: unconditionally goes to IDLE after one cycle.
- `ready`: 1 in DONE, and 1 in IDLE when `req=0`; 0 otherwise. It is combinational from state and `req`.
- `SRAM_WE_N`: 0 in LO and HI on a write; 1 everywhere else. In IDLE and DONE, `SRAM_ADDR=0` and `SRAM_WDATA=0`.
- Inputs are guaranteed stable for the whole access, because the EXE stage register is frozen while `ready=0`.
- A write leaves `MEM_result` unchanged.

## Timing
- Reset values: state IDLE, counter 0, `MEM_result=0`, `SRAM_WE_N=1`, `SRAM_ADDR=0`, `SRAM_WDATA=0`. `ready=1` when no request is present.
- Stall length:
  - `ready` stays low for `1 + 2*(SRAM_WAIT+1)` cycles (5 cycles at the default). `ready` is high in the following DONE cycle.
  - `MEM_result` is valid from the DONE cycle onward and holds until the next read completes.
- DONE is the only cycle in which the EXE stage register advances for a memory instruction. The DONE→IDLE transition therefore sees the next instruction, and the same request is never served twice.
- Back-to-back memory instructions: IDLE immediately re-enters LO. Each access costs the full stall.
- `rst` mid-access: the state machine returns to IDLE asynchronously and `SRAM_WE_N` goes to 1 at once. A partial write is not repeated.
- `SRAM_WAIT=0`: each phase lasts 1 cycle and `ready` is low for 3 cycles.

## Structure
- Shared package `arm_pkg`:
  - state enum `mem_state_t` (IDLE, LO, HI, DONE);
  - `SRAM_ADDR_W=18`;
  - default `BASE_ADDR`.
- One sub-module, `sram_ctrl`, holds the state machine, wait counter, SRAM drive, read latch and `ready`.
- `mem_stage_sram` instantiates `sram_ctrl` and does the pass-through wiring and address translation.

## Test plan
- Reset, then a non-memory instruction with `WB_en_in=1`, `ALU_result_in=0x55`: `ready=1` every cycle, `ALU_result=0x55`, `SRAM_WE_N=1`.
- Store `ALU_result_in=1028`, `ST_val_in=0xDEADBEEF`, `SRAM_WAIT=1`:
  - `SRAM_ADDR=2` with `SRAM_WDATA=0xBEEF` for 2 cycles;
  - then `SRAM_ADDR=3` with `0xDEAD` for 2 cycles, `SRAM_WE_N=0` throughout;
  - `ready` low for 5 cycles, then high.
- Load from 1028 against an SRAM model holding the previous store: `MEM_result=0xDEADBEEF` in the DONE cycle, with the same 5-cycle stall.
- Back-to-back store then load at the same address: two separate stalls, the load returns the stored word, and the store is not duplicated.
- Both `MEM_R_EN_in` and `MEM_W_EN_in` set: a write is performed and `MEM_result` is unchanged. Separately, address 1020 maps to `waddr=0x1FFFF`.
- `rst` pulsed during the HI phase: `SRAM_WE_N=1` and `ready` follows `req` immediately, `MEM_result=0`, and the next request starts cleanly from LO.

Source files
------------

// File: rtl/arm_pkg.sv
// Purpose: shared types and constants for the memory stage and its SRAM controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arm_pkg;

  // Access sequencer states: two halfword phases, then a one-cycle release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int          SRAM_ADDR_W       = 18;
  localparam int          SRAM_WAIT_W       = 4;   // wait states 0..15
  localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1024;

endpackage

// File: rtl/mem_stage_sram_if.sv
// Purpose: external 16-bit SRAM bus between the memory stage and the SRAM device.
// Latency: none (wires only); read data is sampled by the master in the same cycle.
// Backpressure: none on the bus; the master stalls the pipeline while it sequences an access.
// Signals: SRAM_ADDR (halfword address), SRAM_WDATA, SRAM_WE_N (active low), SRAM_RDATA.
// Modports: master = memory stage, slave = SRAM device.
interface mem_stage_sram_if;

  logic [arm_pkg::SRAM_ADDR_W-1:0] SRAM_ADDR;
  logic [15:0]                     SRAM_WDATA;
  logic [15:0]                     SRAM_RDATA;
  logic                            SRAM_WE_N;

  modport master (
    output SRAM_ADDR,
    output SRAM_WDATA,
    output SRAM_WE_N,
    input  SRAM_RDATA
  );

  modport slave (
    input  SRAM_ADDR,
    input  SRAM_WDATA,
    input  SRAM_WE_N,
    output SRAM_RDATA
  );

endinterface

// File: rtl/sram_ctrl.sv
// Purpose: sequences one 32-bit load/store as a low then a high halfword SRAM access.
// Latency: ready low for 1 + 2*(SRAM_WAIT+1) cycles per access; read word valid from DONE on.
// Backpressure: ready=0 freezes the pipeline; request inputs must stay stable until DONE.
// Ports: clk, rst (async, active high); req/wr/waddr/wdata from the memory stage;
//        ready and mem_result back to it; sram = master side of the SRAM bus.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int SRAM_WAIT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req,
  input  logic                  wr,
  input  logic [16:0]           waddr,
  input  logic [31:0]           wdata,
  output logic                  ready,
  output logic [31:0]           mem_result,
  mem_stage_sram_if.master      sram
);

  localparam logic [SRAM_WAIT_W-1:0] WAIT_LAST = SRAM_WAIT_W'(SRAM_WAIT);

  mem_state_t              state;
  mem_state_t              state_nxt;
  logic [SRAM_WAIT_W-1:0]  cnt;
  logic                    phase_end;

  logic [SRAM_ADDR_W-1:0]  addr_d;
  logic [15:0]             wdata_d;
  logic                    we_n_d;

  // The last wait cycle of a halfword phase; the phase's edge happens at its end.
  assign phase_end = (cnt == WAIT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (req)       state_nxt = LO;
      LO:   if (phase_end) state_nxt = HI;
      HI:   if (phase_end) state_nxt = DONE;
      DONE:                state_nxt = IDLE;
    endcase
  end

  // Wait counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      mem_result <= '0;
    end else begin
      case (state)
        LO, HI: begin
          if (phase_end) begin
            cnt <= '0;
            if (!wr) begin
              if (state == LO) mem_result[15:0]  <= sram.SRAM_RDATA;
              else             mem_result[31:16] <= sram.SRAM_RDATA;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Outputs: bus is parked at zero with writes disabled outside the two phases.
  always_comb begin
    ready   = 1'b0;
    addr_d  = '0;
    wdata_d = '0;
    we_n_d  = 1'b1;
    case (state)
      IDLE: ready = ~req;
      LO: begin
        addr_d = {waddr, 1'b0};
        if (wr) begin
          wdata_d = wdata[15:0];
          we_n_d  = 1'b0;
        end
      end
      HI: begin
        addr_d = {waddr, 1'b1};
        if (wr) begin
          wdata_d = wdata[31:16];
          we_n_d  = 1'b0;
        end
      end
      DONE: ready = 1'b1;
    endcase
  end

  assign sram.SRAM_ADDR  = addr_d;
  assign sram.SRAM_WDATA = wdata_d;
  assign sram.SRAM_WE_N  = we_n_d;

endmodule

// File: rtl/mem_stage_sram.sv
// Purpose: pipeline memory stage; passes non-memory results through, maps loads/stores to SRAM.
// Latency: pass-through outputs combinational; memory access stalls 1 + 2*(SRAM_WAIT+1) cycles.
// Backpressure: ready=0 while an access is pending (pipeline freeze = ~ready).
// Ports: clk, rst; *_in from the EXE stage register; WB_en/MEM_R_EN/ALU_result/Dest pass-through;
//        MEM_result (registered read word), ready; sram = master side of the SRAM bus.
module mem_stage_sram
  import arm_pkg::*;
#(
  parameter int          SRAM_WAIT = 1,
  parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             WB_en_in,
  input  logic             MEM_R_EN_in,
  input  logic             MEM_W_EN_in,
  input  logic [31:0]      ALU_result_in,
  input  logic [31:0]      ST_val_in,
  input  logic [3:0]       Dest_in,
  output logic             WB_en,
  output logic             MEM_R_EN,
  output logic [31:0]      ALU_result,
  output logic [3:0]       Dest,
  output logic [31:0]      MEM_result,
  output logic             ready,
  mem_stage_sram_if.master sram
);

  logic        req;
  logic [16:0] waddr;

  assign WB_en      = WB_en_in;
  assign MEM_R_EN   = MEM_R_EN_in;
  assign ALU_result = ALU_result_in;
  assign Dest       = Dest_in;

  // A simultaneous read and write request is served as a write.
  assign req = MEM_R_EN_in | MEM_W_EN_in;

  // Byte address to SRAM word index; addresses below BASE_ADDR wrap silently.
  assign waddr = 17'((ALU_result_in - BASE_ADDR) >> 2);

  sram_ctrl #(
    .SRAM_WAIT (SRAM_WAIT)
  ) u_sram_ctrl (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .wr         (MEM_W_EN_in),
    .waddr      (waddr),
    .wdata      (ST_val_in),
    .ready      (ready),
    .mem_result (MEM_result),
    .sram       (sram)
  );

endmodule

// File: tb/tb_mem_stage_sram.sv
// Purpose: directed self-checking bench for mem_stage_sram (default wait states plus a zero-wait copy).
// Latency: expects ready low for 5 cycles (SRAM_WAIT=1) and 3 cycles (SRAM_WAIT=0).
// Backpressure: bench acts as the EXE stage register, advancing only on the DONE cycle.
module tb_mem_stage_sram;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        WB_en_in = 1'b0, MEM_R_EN_in = 1'b0, MEM_W_EN_in = 1'b0;
  logic [31:0] ALU_result_in = '0, ST_val_in = '0;
  logic [3:0]  Dest_in = '0;
  logic        WB_en, MEM_R_EN, ready;
  logic [31:0] ALU_result, MEM_result;
  logic [3:0]  Dest;

  // zero-wait instance has its own request lines, shares address/data
  logic        r1_en = 1'b0;
  logic        wb1, mr1, ready1;
  logic [31:0] alu1, res1;
  logic [3:0]  dest1;

  mem_stage_sram_if s0 ();
  mem_stage_sram_if s1 ();

  mem_stage_sram #(.SRAM_WAIT(1), .BASE_ADDR(32'd1024)) dut (
    .clk(clk), .rst(rst), .WB_en_in(WB_en_in), .MEM_R_EN_in(MEM_R_EN_in),
    .MEM_W_EN_in(MEM_W_EN_in), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
    .Dest_in(Dest_in), .WB_en(WB_en), .MEM_R_EN(MEM_R_EN), .ALU_result(ALU_result),
    .Dest(Dest), .MEM_result(MEM_result), .ready(ready), .sram(s0)
  );

  mem_stage_sram #(.SRAM_WAIT(0), .BASE_ADDR(32'd1024)) dut_w0 (
    .clk(clk), .rst(rst), .WB_en_in(r1_en), .MEM_R_EN_in(r1_en),
    .MEM_W_EN_in(1'b0), .ALU_result_in(ALU_result_in), .ST_val_in(ST_val_in),
    .Dest_in(Dest_in), .WB_en(wb1), .MEM_R_EN(mr1), .ALU_result(alu1),
    .Dest(dest1), .MEM_result(res1), .ready(ready1), .sram(s1)
  );

  // SRAM model for the main instance
  logic [15:0] mem [0:262143];
  int          wr_cnt = 0;
  always @(posedge clk) begin
    if (s0.SRAM_WE_N == 1'b0) begin
      mem[s0.SRAM_ADDR] <= s0.SRAM_WDATA;
      wr_cnt <= wr_cnt + 1;
    end
  end
  assign s0.SRAM_RDATA = mem[s0.SRAM_ADDR];

  // Zero-wait instance reads a fixed pattern derived from the address
  assign s1.SRAM_RDATA = s1.SRAM_ADDR[15:0] ^ 16'hA000;

  int checks = 0;
  int errors = 0;

  logic        cap_rdy  [6];
  logic [17:0] cap_addr [6];
  logic [15:0] cap_wd   [6];
  logic        cap_wen  [6];
  logic [31:0] cap_res  [6];

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    MEM_R_EN_in   = r;
    MEM_W_EN_in   = w;
    WB_en_in      = r;
    ALU_result_in = a;
    ST_val_in     = d;
    Dest_in       = 4'h3;
  endtask

  // Sample six cycles from the request cycle through DONE
  task automatic capture6();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      cap_rdy[i]  = ready;
      cap_addr[i] = s0.SRAM_ADDR;
      cap_wd[i]   = s0.SRAM_WDATA;
      cap_wen[i]  = s0.SRAM_WE_N;
      cap_res[i]  = MEM_result;
    end
  endtask

  // Count stall cycles until ready; gives up after 40 (reported as a wrong stall count)
  task automatic measure(output int stall, output logic [31:0] res);
    stall = 0;
    res   = '0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (ready) begin
        res = MEM_result;
        return;
      end
      stall++;
    end
  endtask

  task automatic test_reset();
    #12;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", ready); end
    checks++; if (MEM_result !== 32'h0) begin errors++; $display("FAIL reset_mem_result got %h want 0", MEM_result); end
    checks++; if (s0.SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL reset_we_n got %b want 1", s0.SRAM_WE_N); end
    checks++; if (s0.SRAM_ADDR !== 18'h0) begin errors++; $display("FAIL reset_addr got %h want 0", s0.SRAM_ADDR); end
    checks++; if (s0.SRAM_WDATA !== 16'h0) begin errors++; $display("FAIL reset_wdata got %h want 0", s0.SRAM_WDATA); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_nonmem();
    @(posedge clk); #1;
    WB_en_in = 1'b1; ALU_result_in = 32'h55; Dest_in = 4'h7;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin errors++; $display("FAIL nonmem_ready[%0d] got %b want 1", i, ready); end
      checks++; if (ALU_result !== 32'h55) begin errors++; $display("FAIL nonmem_alu[%0d] got %h want 55", i, ALU_result); end
      checks++; if (s0.SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL nonmem_we_n[%0d] got %b want 1", i, s0.SRAM_WE_N); end
    end
    checks++; if (WB_en !== 1'b1 || Dest !== 4'h7 || MEM_R_EN !== 1'b0) begin
      errors++; $display("FAIL nonmem_passthru got wb=%b dest=%h mr=%b want 1 7 0", WB_en, Dest, MEM_R_EN);
    end
  endtask

  task automatic test_store();
    logic        er [6];
    logic [17:0] ea [6];
    logic [15:0] ew [6];
    logic        en [6];
    int          wr0;
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ea = '{18'd0, 18'd2, 18'd2, 18'd3, 18'd3, 18'd0};
    ew = '{16'h0, 16'hBEEF, 16'hBEEF, 16'hDEAD, 16'hDEAD, 16'h0};
    en = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    en = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    drive(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
    wr0 = wr_cnt;
    capture6();
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_rdy[i] !== er[i]) begin errors++; $display("FAIL store_ready[%0d] got %b want %b", i, cap_rdy[i], er[i]); end
      checks++; if (cap_addr[i] !== ea[i]) begin errors++; $display("FAIL store_addr[%0d] got %h want %h", i, cap_addr[i], ea[i]); end
      checks++; if (cap_wd[i] !== ew[i]) begin errors++; $display("FAIL store_wdata[%0d] got %h want %h", i, cap_wd[i], ew[i]); end
      checks++; if (cap_wen[i] !== en[i]) begin errors++; $display("FAIL store_we_n[%0d] got %b want %b", i, cap_wen[i], en[i]); end
    end
    checks++; if (mem[2] !== 16'hBEEF || mem[3] !== 16'hDEAD) begin
      errors++; $display("FAIL store_mem got %h %h want beef dead", mem[2], mem[3]);
    end
    checks++; if (wr_cnt - wr0 !== 4) begin errors++; $display("FAIL store_wr_count got %0d want 4", wr_cnt - wr0); end
    drive(1'b0, 1'b0, 32'h55, 32'h0);
  endtask

  task automatic test_load();
    logic        er [6];
    logic [17:0] ea [6];
    er = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    ea = '{18'd0, 18'd2, 18'd2, 18'd3, 18'd3, 18'd0};
    drive(1'b1, 1'b0, 32'd1028, 32'h0);
    capture6();
    for (int i = 0; i < 6; i++) begin
      checks++; if (cap_rdy[i] !== er[i]) begin errors++; $display("FAIL load_ready[%0d] got %b want %b", i, cap_rdy[i], er[i]); end
      checks++; if (cap_addr[i] !== ea[i]) begin errors++; $display("FAIL load_addr[%0d] got %h want %h", i, cap_addr[i], ea[i]); end
      checks++; if (cap_wen[i] !== 1'b1) begin errors++; $display("FAIL load_we_n[%0d] got %b want 1", i, cap_wen[i]); end
    end
    checks++; if (cap_res[3][15:0] !== 16'hBEEF) begin errors++; $display("FAIL load_low_half got %h want beef", cap_res[3][15:0]); end
    checks++; if (cap_res[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL load_result got %h want deadbeef", cap_res[5]); end
    drive(1'b0, 1'b0, 32'h55, 32'h0);
  endtask

  task automatic test_back_to_back();
    int          st1, st2, wr0;
    logic [31:0] r1, r2;
    drive(1'b0, 1'b1, 32'd1032, 32'h12345678);
    wr0 = wr_cnt;
    measure(st1, r1);
    drive(1'b1, 1'b0, 32'd1032, 32'h0);
    measure(st2, r2);
    drive(1'b0, 1'b0, 32'h55, 32'h0);
    checks++; if (st1 !== 5) begin errors++; $display("FAIL b2b_store_stall got %0d want 5", st1); end
    checks++; if (st2 !== 5) begin errors++; $display("FAIL b2b_load_stall got %0d want 5", st2); end
    checks++; if (r2 !== 32'h12345678) begin errors++; $display("FAIL b2b_load_result got %h want 12345678", r2); end
    checks++; if (wr_cnt - wr0 !== 4) begin errors++; $display("FAIL b2b_wr_count got %0d want 4", wr_cnt - wr0); end
    checks++; if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234) begin
      errors++; $display("FAIL b2b_mem got %h %h want 5678 1234", mem[4], mem[5]);
    end
  endtask

  task automatic test_both_and_wrap();
    int          st, wr0;
    logic [31:0] r;
    drive(1'b1, 1'b1, 32'd1036, 32'hCAFEF00D);
    wr0 = wr_cnt;
    measure(st, r);
    checks++; if (st !== 5) begin errors++; $display("FAIL both_stall got %0d want 5", st); end
    checks++; if (r !== 32'h12345678) begin errors++; $display("FAIL both_result got %h want 12345678", r); end
    checks++; if (wr_cnt - wr0 !== 4) begin errors++; $display("FAIL both_wr_count got %0d want 4", wr_cnt - wr0); end
    checks++; if (mem[6] !== 16'hF00D || mem[7] !== 16'hCAFE) begin
      errors++; $display("FAIL both_mem got %h %h want f00d cafe", mem[6], mem[7]);
    end
    drive(1'b0, 1'b1, 32'd1020, 32'hA5A55A5A);
    capture6();
    checks++; if (cap_addr[1] !== 18'h3FFFE) begin errors++; $display("FAIL wrap_addr_lo got %h want 3fffe", cap_addr[1]); end
    checks++; if (cap_addr[3] !== 18'h3FFFF) begin errors++; $display("FAIL wrap_addr_hi got %h want 3ffff", cap_addr[3]); end
    checks++; if (cap_wd[1] !== 16'h5A5A || cap_wen[1] !== 1'b0) begin
      errors++; $display("FAIL wrap_wdata got %h we_n %b want 5a5a 0", cap_wd[1], cap_wen[1]);
    end
    drive(1'b0, 1'b0, 32'h55, 32'h0);
  endtask

  task automatic test_reset_mid();
    int wr0;
    drive(1'b0, 1'b1, 32'd1040, 32'h11112222);
    wr0 = wr_cnt;
    repeat (4) @(negedge clk);   // request, LO, LO, first HI cycle
    checks++; if (s0.SRAM_WE_N !== 1'b0 || s0.SRAM_ADDR !== 18'd9) begin
      errors++; $display("FAIL rstmid_in_hi got we_n=%b addr=%h want 0 9", s0.SRAM_WE_N, s0.SRAM_ADDR);
    end
    #1 rst = 1'b1;
    #1;
    checks++; if (s0.SRAM_WE_N !== 1'b1) begin errors++; $display("FAIL rstmid_we_n got %b want 1", s0.SRAM_WE_N); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rstmid_ready_req got %b want 0", ready); end
    checks++; if (MEM_result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h want 0", MEM_result); end
    MEM_R_EN_in = 1'b0; MEM_W_EN_in = 1'b0; WB_en_in = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready_idle got %b want 1", ready); end
    rst = 1'b0;
    checks++; if (mem[9] === 16'h1111) begin errors++; $display("FAIL rstmid_partial got %h want not 1111", mem[9]); end
    checks++; if (wr_cnt - wr0 !== 2) begin errors++; $display("FAIL rstmid_wr_count got %0d want 2", wr_cnt - wr0); end
    drive(1'b1, 1'b0, 32'd1028, 32'h0);
    capture6();
    checks++; if (cap_rdy[0] !== 1'b0 || cap_rdy[4] !== 1'b0 || cap_rdy[5] !== 1'b1) begin
      errors++; $display("FAIL rstmid_next_ready got %b%b%b want 001", cap_rdy[0], cap_rdy[4], cap_rdy[5]);
    end
    checks++; if (cap_addr[1] !== 18'd2 || cap_addr[3] !== 18'd3) begin
      errors++; $display("FAIL rstmid_next_addr got %h %h want 2 3", cap_addr[1], cap_addr[3]);
    end
    checks++; if (cap_res[5] !== 32'hDEADBEEF) begin errors++; $display("FAIL rstmid_next_result got %h want deadbeef", cap_res[5]); end
    drive(1'b0, 1'b0, 32'h55, 32'h0);
  endtask

  task automatic test_wait0();
    int          st;
    logic [31:0] r;
    logic [17:0] a_lo;
    logic        done;
    st = 0; r = '0; a_lo = '0; done = 1'b0;
    @(posedge clk); #1;
    ALU_result_in = 32'd1028;
    r1_en = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (i == 1) a_lo = s1.SRAM_ADDR;
      if (ready1) begin
        r = res1;
        done = 1'b1;
      end else begin
        st++;
      end
    end
    checks++; if (mr1 !== 1'b1 || wb1 !== 1'b1 || alu1 !== 32'd1028 || dest1 !== Dest_in) begin
      errors++; $display("FAIL w0_passthru got mr=%b wb=%b alu=%h dest=%h", mr1, wb1, alu1, dest1);
    end
    @(posedge clk); #1;
    r1_en = 1'b0;
    checks++; if (st !== 3) begin errors++; $display("FAIL w0_stall got %0d want 3", st); end
    checks++; if (a_lo !== 18'd2) begin errors++; $display("FAIL w0_addr_lo got %h want 2", a_lo); end
    checks++; if (r !== 32'hA003A002) begin errors++; $display("FAIL w0_result got %h want a003a002", r); end
  endtask

  initial begin
    test_reset();
    test_nonmem();
    test_store();
    test_load();
    test_back_to_back();
    test_both_and_wrap();
    test_reset_mid();
    test_wait0();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
